cskipa_43bit_accum: RTL and testbench
=====================================

Name: cskipa_43bit_accum

Overview:
- Burst accumulator built around the team's 43-bit carry-skip adder (CSkipA_43bit). The adder is instantiated with the accumulator register and the incoming term as its two operands.
- Accepts a stream of 43-bit terms over a valid/ready handshake and sums them into a register. The adder's sum and cout feed back into that register.
- When the beat flagged as last is accepted, the block presents the final sum, a sticky overflow flag and a term count on an output valid/ready handshake.
- Sits downstream of operand producers and upstream of result consumers in the adder-evaluation datapath.

Parameters:
- WIDTH, 43, operand/accumulator width; must match the adder instance.
- COUNT_W, 8, width of the term counter.
- SATURATE, 0, overflow policy. 0 = wrap modulo 2^WIDTH. 1 = clamp accumulator to all-ones on carry-out.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input term valid.
- o_ready  output  1  block can accept a term this cycle.
- i_term  input  WIDTH  term to add.
- i_last  input  1  term is the final one of its burst; qualified by i_valid.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.
- o_sum  output  WIDTH  final accumulated sum.
- o_ovf  output  1  sticky flag: at least one add in the burst produced a carry-out.
- o_count  output  COUNT_W  number of terms accepted in the burst, saturating.

Behaviour:
- Reset, taking effect on the next edge while i_rst=1:
  - state=IDLE, accumulator=0, o_sum=0, o_ovf=0, o_count=0, o_valid=0.
  - o_ready=1 from the first cycle after reset.
  - Reset overrides all other events. A burst in progress is discarded, and a pending result is dropped even if i_ready=1.
- Adder connection: term1=accumulator, term2=i_term, carry-in tied 0. Purely combinational; one add per accepted beat.
- Accept condition: i_valid && o_ready. o_ready = (state != DONE). i_term and i_last are ignored when not accepted.
- States:
  - IDLE: accumulator=0, count=0, ovf=0. Accepted beat with i_last=0 -> ACC. Accepted beat with i_last=1 -> DONE.
  - ACC: each accepted beat updates the accumulator. i_last=1 on an accepted beat -> DONE.
  - DONE: o_valid=1 and o_sum/o_ovf/o_count are held stable. On i_valid... none accepted; on (o_valid && i_ready) -> IDLE, clearing accumulator, count and ovf.
- Per accepted beat:
  - SATURATE=0: acc <= sum.
  - SATURATE=1: acc <= cout ? all-ones : sum.
  - ovf <= ovf | cout.
  - count <= (count == 2^COUNT_W-1) ? count : count+1.
- Latency: o_valid rises the cycle after the last beat is accepted. o_sum equals the accumulator register; no combinational path from i_term to o_sum.
- Throughput:
  - One term per cycle within a burst.
  - One bubble after each result handshake: o_ready=0 in DONE, and the next burst is accepted no earlier than the cycle after the handshake.
- Backpressure: while o_valid=1 and i_ready=0, all outputs are held unchanged indefinitely.
- Input gaps: i_valid=0 cycles inside a burst leave all state unchanged.
- o_valid, o_ovf and o_count are meaningful only in DONE. In other states they reflect internal registers, except o_valid, which is 0.

Test Plan:
- Reset: hold i_rst 2 cycles -> o_valid=0, o_ready=1, o_sum=0, o_ovf=0, o_count=0. Then burst 1,2,3 (last on 3), contiguous -> next cycle o_valid=1, o_sum=6, o_ovf=0, o_count=3.
- Overflow, SATURATE=0: terms 0x7FFFFFFFFFF then 1 (last) -> o_sum=0, o_ovf=1, o_count=2. Same stimulus with SATURATE=1 -> o_sum=0x7FFFFFFFFFF, o_ovf=1. Then a new burst with single term 4 -> o_sum=4, o_ovf=0.
- Backpressure: complete burst 10,20 (last), hold i_ready=0 for 5 cycles while driving i_valid=1 with term 99 -> o_sum=30 stable and o_ready=0 throughout. Release i_ready -> handshake, o_ready=1 the next cycle, and 99 is first accepted then.
- Gaps: burst 5,0x100,7 with i_valid low 1-3 cycles between beats -> o_sum=0x10C, o_count=3; identical to the gap-free run.
- Reset mid-burst: accept 8 and 9, then pulse i_rst for 1 cycle -> state cleared, no o_valid. Then single term 7 (last) -> o_sum=7, o_count=1.
- Count saturation, COUNT_W=2: five terms of 1, last on the fifth -> o_sum=5, o_count=3, o_ovf=0.

Source files
------------

// File: rtl/cskipa_43bit_accum.sv
// Burst accumulator around the 43-bit carry-skip adder.
// Terms stream in over valid/ready; the total, a sticky carry flag and a beat count stream out.
module CSkipA_43bit (
    input  logic [42:0] term1,
    input  logic [42:0] term2,
    input  logic        cin,
    output logic [42:0] sum,
    output logic        cout
);
    localparam int BS = 4;
    localparam int NB = 11;

    logic [43:0] a;
    logic [43:0] b;
    logic [43:0] s;

    assign a = {1'b0, term1};
    assign b = {1'b0, term2};

    // Ripple inside each 4-bit block; a fully propagating block passes its carry-in straight through.
    always_comb begin
        logic c;
        logic blk_c;
        logic p;
        logic x;
        s = '0;
        c = cin;
        for (int j = 0; j < NB; j++) begin
            blk_c = c;
            p = 1'b1;
            for (int k = 0; k < BS; k++) begin
                x = a[j*BS+k] ^ b[j*BS+k];
                s[j*BS+k] = x ^ c;
                c = (a[j*BS+k] & b[j*BS+k]) | (c & x);
                p = p & x;
            end
            c = p ? blk_c : c;
        end
    end

    assign sum  = s[42:0];
    assign cout = s[43];
endmodule

module cskipa_43bit_accum #(
    parameter int WIDTH    = 43,
    parameter int COUNT_W  = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [WIDTH-1:0]   i_term,
    input  logic               i_last,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_sum,
    output logic               o_ovf,
    output logic [COUNT_W-1:0] o_count
);
    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic               ovf;
    logic [COUNT_W-1:0] count;
    logic               take;
    logic               hs;

    CSkipA_43bit u_add (
        .term1 (acc),
        .term2 (i_term),
        .cin   (1'b0),
        .sum   (add_sum),
        .cout  (add_cout)
    );

    assign o_ready = (state != DONE);
    assign o_valid = (state == DONE);
    assign take    = i_valid & o_ready;
    assign hs      = o_valid & i_ready;
    assign o_sum   = acc;
    assign o_ovf   = ovf;
    assign o_count = count;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (take) state_nx = i_last ? DONE : ACC;
            ACC:  if (take && i_last) state_nx = DONE;
            DONE: if (i_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
            acc   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            state <= state_nx;
            if (hs) begin
                acc   <= '0;
                ovf   <= 1'b0;
                count <= '0;
            end else if (take) begin
                acc   <= (SATURATE && add_cout) ? '1 : add_sum;
                ovf   <= ovf | add_cout;
                count <= (&count) ? count : count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cskipa_43bit_accum.sv
// Bench for cskipa_43bit_accum: directed table, corner sequences and random bursts.
// Three instances cover wrap, saturate and a narrow counter.
module tb_cskipa_43bit_accum;
    localparam int W = 43;
    localparam logic [63:0] MASK = (64'd1 << W) - 64'd1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         vld;
    logic         last;
    logic         rdy;
    logic [W-1:0] term;

    logic         r0, v0, ov0;
    logic [W-1:0] s0;
    logic [7:0]   c0;
    logic         r1, v1, ov1;
    logic [W-1:0] s1;
    logic [7:0]   c1;
    logic         r2, v2, ov2;
    logic [W-1:0] s2;
    logic [1:0]   c2;

    cskipa_43bit_accum dut0 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(r0),
        .i_term(term), .i_last(last), .o_valid(v0), .i_ready(rdy),
        .o_sum(s0), .o_ovf(ov0), .o_count(c0)
    );

    cskipa_43bit_accum #(.SATURATE(1'b1)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(r1),
        .i_term(term), .i_last(last), .o_valid(v1), .i_ready(rdy),
        .o_sum(s1), .o_ovf(ov1), .o_count(c1)
    );

    cskipa_43bit_accum #(.COUNT_W(2)) dut2 (
        .i_clk(clk), .i_rst(rst), .i_valid(vld), .o_ready(r2),
        .i_term(term), .i_last(last), .o_valid(v2), .i_ready(rdy),
        .o_sum(s2), .o_ovf(ov2), .o_count(c2)
    );

    int checks = 0;
    int failures = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endfunction

    // Reference: a burst is just the list of accepted terms; results come from plain arithmetic.
    logic [W-1:0] cur_q[$];
    logic [W-1:0] done_q[$];
    bit           pend = 1'b0;

    function automatic void eval(input logic [W-1:0] q[$], input bit sat, input int cw,
                                 output logic [63:0] s, output logic ov,
                                 output logic [63:0] cnt);
        logic [63:0] a;
        int lim;
        int n;
        a  = 64'd0;
        ov = 1'b0;
        foreach (q[i]) begin
            a = a + {21'd0, q[i]};
            if (a > MASK) begin
                ov = 1'b1;
                a  = sat ? MASK : a - (MASK + 64'd1);
            end
        end
        s   = a;
        lim = (1 << cw) - 1;
        n   = q.size();
        cnt = 64'(n > lim ? lim : n);
    endfunction

    task automatic model_update();
        if (rst) begin
            cur_q.delete();
            done_q.delete();
            pend = 1'b0;
        end else if (pend) begin
            if (rdy) begin
                pend = 1'b0;
                done_q.delete();
            end
        end else if (vld) begin
            cur_q.push_back(term);
            if (last) begin
                done_q = cur_q;
                cur_q.delete();
                pend = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        logic [W-1:0] q[$];
        logic [63:0]  es;
        logic [63:0]  ec;
        logic         eo;
        q = pend ? done_q : cur_q;
        eval(q, 1'b0, 8, es, eo, ec);
        check("m0_valid", 64'(v0), 64'(pend));
        check("m0_ready", 64'(r0), 64'(!pend));
        check("m0_sum", 64'(s0), es);
        check("m0_ovf", 64'(ov0), 64'(eo));
        check("m0_count", 64'(c0), ec);
        eval(q, 1'b1, 8, es, eo, ec);
        check("m1_valid", 64'(v1), 64'(pend));
        check("m1_sum", 64'(s1), es);
        check("m1_ovf", 64'(ov1), 64'(eo));
        check("m1_count", 64'(c1), ec);
        eval(q, 1'b0, 2, es, eo, ec);
        check("m2_ready", 64'(r2), 64'(!pend));
        check("m2_sum", 64'(s2), es);
        check("m2_ovf", 64'(ov2), 64'(eo));
        check("m2_count", 64'(c2), ec);
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
        model_check();
    endtask

    typedef struct {
        logic        rst;
        logic        v;
        logic [63:0] term;
        logic        last;
        logic        rdy;
        logic        ev;
        logic        er;
        logic [63:0] esum;
        logic [63:0] esat;
        logic        eovf;
        int          ecnt;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic r, input logic v, input logic [63:0] t,
                       input logic l, input logic rd, input logic ev, input logic er,
                       input logic [63:0] es, input logic eo, input int ec,
                       input logic [63:0] esat = 64'hFFFF_FFFF_FFFF_FFFF);
        vec_t x;
        x.rst  = r;
        x.v    = v;
        x.term = t;
        x.last = l;
        x.rdy  = rd;
        x.ev   = ev;
        x.er   = er;
        x.esum = es;
        x.esat = (esat == 64'hFFFF_FFFF_FFFF_FFFF) ? es : esat;
        x.eovf = eo;
        x.ecnt = ec;
        tbl.push_back(x);
    endtask

    initial begin
        rst  = 1'b1;
        vld  = 1'b0;
        last = 1'b0;
        rdy  = 1'b0;
        term = '0;

        row(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        row(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        row(0, 1, 1, 0, 0, 0, 1, 1, 0, 1);
        row(0, 1, 2, 0, 0, 0, 1, 3, 0, 2);
        row(0, 1, 3, 1, 0, 1, 0, 6, 0, 3);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        row(0, 1, MASK, 0, 0, 0, 1, MASK, 0, 1);
        row(0, 1, 1, 1, 0, 1, 0, 0, 1, 2, MASK);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        row(0, 1, 4, 1, 0, 1, 0, 4, 0, 1);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        row(0, 1, 10, 0, 0, 0, 1, 10, 0, 1);
        row(0, 1, 20, 1, 0, 1, 0, 30, 0, 2);
        for (int k = 0; k < 5; k++)
            row(0, 1, 99, 0, 0, 1, 0, 30, 0, 2);
        row(0, 1, 99, 0, 1, 0, 1, 0, 0, 0);
        row(0, 1, 99, 1, 0, 1, 0, 99, 0, 1);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        row(0, 1, 5, 0, 0, 0, 1, 5, 0, 1);
        row(0, 0, 'h55, 1, 0, 0, 1, 5, 0, 1);
        row(0, 1, 'h100, 0, 0, 0, 1, 'h105, 0, 2);
        for (int k = 0; k < 3; k++)
            row(0, 0, 'h77, 1, 0, 0, 1, 'h105, 0, 2);
        row(0, 1, 7, 1, 0, 1, 0, 'h10C, 0, 3);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        row(0, 1, 8, 0, 0, 0, 1, 8, 0, 1);
        row(0, 1, 9, 0, 0, 0, 1, 17, 0, 2);
        row(1, 1, 50, 1, 1, 0, 1, 0, 0, 0);
        row(0, 1, 7, 1, 0, 1, 0, 7, 0, 1);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 5; k++)
            row(0, 1, 1, k == 5, 0, k == 5, k != 5, 64'(k), 0, k);
        row(0, 0, 0, 0, 1, 0, 1, 0, 0, 0);

        foreach (tbl[i]) begin
            rst  = tbl[i].rst;
            vld  = tbl[i].v;
            term = tbl[i].term[W-1:0];
            last = tbl[i].last;
            rdy  = tbl[i].rdy;
            step();
            check($sformatf("t%0d_valid", i), 64'(v0), 64'(tbl[i].ev));
            check($sformatf("t%0d_ready", i), 64'(r0), 64'(tbl[i].er));
            check($sformatf("t%0d_sum", i), 64'(s0), tbl[i].esum);
            check($sformatf("t%0d_sat_sum", i), 64'(s1), tbl[i].esat);
            check($sformatf("t%0d_ovf", i), 64'(ov0), 64'(tbl[i].eovf));
            check($sformatf("t%0d_count", i), 64'(c0), 64'(tbl[i].ecnt));
            check($sformatf("t%0d_c2_count", i), 64'(c2),
                  64'(tbl[i].ecnt > 3 ? 3 : tbl[i].ecnt));
        end

        // Reset drops a pending result even with the consumer ready.
        rst = 1'b0; vld = 1'b1; term = 43'd3; last = 1'b1; rdy = 1'b0;
        step();
        check("pend_valid", 64'(v0), 64'd1);
        rst = 1'b1; rdy = 1'b1; term = 43'd9;
        step();
        check("drop_valid", 64'(v0), 64'd0);
        check("drop_sum", 64'(s0), 64'd0);
        rst = 1'b0; vld = 1'b0;
        step();
        check("drop_ready", 64'(r0), 64'd1);
        check("drop_count", 64'(c0), 64'd0);

        // Long burst saturates the 8-bit counter.
        rdy = 1'b0; vld = 1'b1; term = 43'd1;
        for (int k = 1; k <= 260; k++) begin
            last = (k == 260);
            step();
        end
        check("long_valid", 64'(v0), 64'd1);
        check("long_sum", 64'(s0), 64'd260);
        check("long_count", 64'(c0), 64'd255);
        check("long_c2_count", 64'(c2), 64'd3);
        vld = 1'b0; last = 1'b0; rdy = 1'b1;
        step();

        for (int n = 0; n < 1500; n++) begin
            rst  = ($urandom_range(0, 80) == 0);
            vld  = ($urandom_range(0, 9) < 7);
            last = ($urandom_range(0, 5) == 0);
            rdy  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 3))
                0: term = W'($urandom_range(0, 15));
                1: term = W'({$urandom, $urandom});
                2: term = W'(MASK - 64'($urandom_range(0, 3)));
                default: term = W'(64'd1 << (W - 1));
            endcase
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
